// File: rtl/icc_sync_pkg.sv
// Shared constants, word classes and state encoding for the clock-sync word receiver.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package icc_sync_pkg;

    localparam logic [15:0] IDLE_WORD = 16'h00bc;
    localparam logic [15:0] AREQ_WORD = 16'h01bc;
    localparam logic [1:0]  K_LOW     = 2'b01;

    // Data word layout: {action[4:0], index[2:0], byte[7:0]}
    localparam int ACT_MSB  = 15;
    localparam int ACT_LSB  = 11;
    localparam int IDX_MSB  = 10;
    localparam int IDX_LSB  = 8;
    localparam int BYTE_MSB = 7;
    localparam int BYTE_LSB = 0;

    typedef enum logic [4:0] {
        ACT_NONE = 5'd0,
        ACT_T1   = 5'd1,
        ACT_T2   = 5'd2,
        ACT_T3   = 5'd3,
        ACT_T4   = 5'd4
    } act_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        W_IDLEW,
        W_AREQ,
        W_BADK,
        W_DATA,
        W_BADCODE
    } wcls_e;

    // Code errors dominate: a word with a bad symbol cannot be trusted as anything else.
    function automatic wcls_e classify(input logic [15:0] d, input logic [1:0] k,
                                       input logic [1:0] de, input logic [1:0] nt);
        wcls_e c;
        if ((|de) || (|nt))                 c = W_BADCODE;
        else if (k == K_LOW && d == IDLE_WORD) c = W_IDLEW;
        else if (k == K_LOW && d == AREQ_WORD) c = W_AREQ;
        else if (k != 2'b00)                c = W_BADK;
        else                                c = W_DATA;
        return c;
    endfunction

    function automatic logic is_ts_act(input logic [4:0] a);
        return (a >= ACT_T1) && (a <= ACT_T4);
    endfunction

endpackage

// File: rtl/icc_sat_counter.sv
// Saturating event counter with synchronous clear (clear beats increment).
// Latency: count updates on the edge after inc_i.
// Backpressure: none; every increment pulse is accepted.
module icc_sat_counter #(
    parameter int CNTW = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clr_i,
    input  logic            inc_i,
    output logic [CNTW-1:0] cnt_o
);

    logic [CNTW-1:0] cnt_q, cnt_d;

    // Next count: clear first, otherwise increment unless already all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q != {CNTW{1'b1}}))
            cnt_d = cnt_q + CNTW'(1);
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/icc_sync_rx.sv
// Decodes 8-word clock-sync frames from the GT rx stream into 64-bit timestamps plus arrival time.
// Latency: 2 clk from last frame word at the pins to ts_valid.
// Backpressure: none; the consumer must take every ts_valid/alignreq/frame_err strobe.
module icc_sync_rx
    import icc_sync_pkg::*;
#(
    parameter int DWIDTH = 16,
    parameter int CNTW   = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [DWIDTH-1:0] rxdata,
    input  logic [1:0]        rxcharisk,
    input  logic [1:0]        rxdisperr,
    input  logic [1:0]        rxnotintable,
    input  logic              rxbyteisaligned,
    input  logic [63:0]       localts,
    input  logic              clr_cnt,
    output logic              ts_valid,
    output logic [4:0]        ts_action,
    output logic [63:0]       ts_value,
    output logic [63:0]       ts_arrival,
    output logic              alignreq,
    output logic              frame_err,
    output logic [CNTW-1:0]   frame_err_cnt,
    output logic [CNTW-1:0]   code_err_cnt
);

    logic [DWIDTH-1:0] rxdata_q;
    logic [1:0]        charisk_q, disperr_q, notintable_q;
    logic              aligned_q;
    logic [63:0]       localts_q;

    state_e      state_q, state_d;
    logic [7:0]  mask_q, mask_d;
    logic [63:0] buf_q, buf_d;
    logic [4:0]  act_q, act_d;
    logic [63:0] arr_q, arr_d;
    logic        ts_valid_q, ts_valid_d;
    logic [4:0]  ts_action_q, ts_action_d;
    logic [63:0] ts_value_q, ts_value_d;
    logic [63:0] ts_arrival_q, ts_arrival_d;
    logic        alignreq_q, alignreq_d;
    logic        frame_err_q, frame_err_d;

    wcls_e       wcls;
    logic [4:0]  w_act;
    logic [2:0]  w_idx;
    logic [7:0]  w_byte;
    logic [7:0]  w_bit;

    assign wcls   = classify(rxdata_q, charisk_q, disperr_q, notintable_q);
    assign w_act  = rxdata_q[ACT_MSB:ACT_LSB];
    assign w_idx  = rxdata_q[IDX_MSB:IDX_LSB];
    assign w_byte = rxdata_q[BYTE_MSB:BYTE_LSB];
    assign w_bit  = 8'b1 << w_idx;

    // Input stage: word, status and local time captured together so arrival time lines up with the word.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rxdata_q     <= '0;
            charisk_q    <= '0;
            disperr_q    <= '0;
            notintable_q <= '0;
            aligned_q    <= 1'b0;
            localts_q    <= '0;
        end else begin
            rxdata_q     <= rxdata;
            charisk_q    <= rxcharisk;
            disperr_q    <= rxdisperr;
            notintable_q <= rxnotintable;
            aligned_q    <= rxbyteisaligned;
            localts_q    <= localts;
        end
    end

    // Frame assembly FSM; DONE behaves like IDLE for the incoming word so back-to-back frames lose nothing.
    // Index i lands in byte lane 7-i, i.e. bit offset {~i,3'b000}.
    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        buf_d        = buf_q;
        act_d        = act_q;
        arr_d        = arr_q;
        ts_valid_d   = 1'b0;
        ts_action_d  = ts_action_q;
        ts_value_d   = ts_value_q;
        ts_arrival_d = ts_arrival_q;
        frame_err_d  = 1'b0;
        alignreq_d   = (wcls == W_AREQ);

        if (!aligned_q) begin
            frame_err_d = (state_q == ST_COLLECT);
            state_d     = ST_IDLE;
            mask_d      = '0;
        end else begin
            case (state_q)
                ST_COLLECT: begin
                    if (wcls == W_DATA && w_act == act_q && !mask_q[w_idx]) begin
                        mask_d = mask_q | w_bit;
                        buf_d[{~w_idx, 3'b000} +: 8] = w_byte;
                        if (mask_d == 8'hff) begin
                            state_d      = ST_DONE;
                            mask_d       = '0;
                            ts_valid_d   = 1'b1;
                            ts_action_d  = act_q;
                            ts_value_d   = buf_d;
                            ts_arrival_d = arr_q;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        mask_d      = '0;
                        state_d     = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    mask_d  = '0;
                    if (wcls == W_DATA && is_ts_act(w_act)) begin
                        mask_d = w_bit;
                        buf_d[{~w_idx, 3'b000} +: 8] = w_byte;
                        act_d   = w_act;
                        arr_d   = localts_q;
                        state_d = ST_COLLECT;
                    end
                end
            endcase
        end
    end

    // FSM, assembly buffer and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            mask_q       <= '0;
            buf_q        <= '0;
            act_q        <= '0;
            arr_q        <= '0;
            ts_valid_q   <= 1'b0;
            ts_action_q  <= '0;
            ts_value_q   <= '0;
            ts_arrival_q <= '0;
            alignreq_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            buf_q        <= buf_d;
            act_q        <= act_d;
            arr_q        <= arr_d;
            ts_valid_q   <= ts_valid_d;
            ts_action_q  <= ts_action_d;
            ts_value_q   <= ts_value_d;
            ts_arrival_q <= ts_arrival_d;
            alignreq_q   <= alignreq_d;
            frame_err_q  <= frame_err_d;
        end
    end

    icc_sat_counter #(.CNTW(CNTW)) u_frame_err_cnt (
        .clk_i  (clk),
        .rst_ni (resetn),
        .clr_i  (clr_cnt),
        .inc_i  (frame_err_d),
        .cnt_o  (frame_err_cnt)
    );

    icc_sat_counter #(.CNTW(CNTW)) u_code_err_cnt (
        .clk_i  (clk),
        .rst_ni (resetn),
        .clr_i  (clr_cnt),
        .inc_i  (wcls == W_BADCODE),
        .cnt_o  (code_err_cnt)
    );

    assign ts_valid   = ts_valid_q;
    assign ts_action  = ts_action_q;
    assign ts_value   = ts_value_q;
    assign ts_arrival = ts_arrival_q;
    assign alignreq   = alignreq_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_icc_sync_rx.sv
// Scoreboard bench for icc_sync_rx: expected frames queued at drive time, checked on ts_valid.
// Latency: expects ts_valid exactly 2 clk after the last frame word is presented.
// Backpressure: none modelled; every strobe is observed by the monitor.
module tb_icc_sync_rx;

    localparam int CNTW = 16;

    logic            clk = 1'b0;
    logic            resetn;
    logic [15:0]     rxdata;
    logic [1:0]      rxcharisk, rxdisperr, rxnotintable;
    logic            rxbyteisaligned;
    logic [63:0]     localts;
    logic            clr_cnt;
    logic            ts_valid;
    logic [4:0]      ts_action;
    logic [63:0]     ts_value, ts_arrival;
    logic            alignreq, frame_err;
    logic [CNTW-1:0] frame_err_cnt, code_err_cnt;

    icc_sync_rx #(.DWIDTH(16), .CNTW(CNTW)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .rxdata          (rxdata),
        .rxcharisk       (rxcharisk),
        .rxdisperr       (rxdisperr),
        .rxnotintable    (rxnotintable),
        .rxbyteisaligned (rxbyteisaligned),
        .localts         (localts),
        .clr_cnt         (clr_cnt),
        .ts_valid        (ts_valid),
        .ts_action       (ts_action),
        .ts_value        (ts_value),
        .ts_arrival      (ts_arrival),
        .alignreq        (alignreq),
        .frame_err       (frame_err),
        .frame_err_cnt   (frame_err_cnt),
        .code_err_cnt    (code_err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  act;
        logic [63:0] val;
        logic [63:0] arr;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc     = 0;
    int   n_chk   = 0;
    int   n_fail  = 0;
    int   fe_seen = 0;
    int   al_seen = 0;
    int   fe_mark;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops one expected frame per ts_valid and tallies error/align pulses.
    always @(posedge clk) begin
        #1;
        if (resetn === 1'b1 && ts_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check_eq("ts_valid_unexpected", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check_eq("ts_action", 64'(ts_action), 64'(mon_e.act));
                check_eq("ts_value", ts_value, mon_e.val);
                check_eq("ts_arrival", ts_arrival, mon_e.arr);
                check_eq("ts_latency_cycle", 64'(cyc), 64'(mon_e.cyc));
            end
        end
        if (frame_err === 1'b1) fe_seen++;
        if (alignreq === 1'b1)  al_seen++;
    end

    task automatic send(input logic [15:0] d, input logic [1:0] k,
                        input logic [1:0] de, input logic [1:0] nt);
        rxdata       = d;
        rxcharisk    = k;
        rxdisperr    = de;
        rxnotintable = nt;
        @(negedge clk);
    endtask

    task automatic send_idle(input int n);
        for (int i = 0; i < n; i++) send(16'h00bc, 2'b01, 2'b00, 2'b00);
    endtask

    task automatic send_data(input logic [4:0] act, input logic [2:0] idx, input logic [7:0] b);
        send({act, idx, b}, 2'b00, 2'b00, 2'b00);
    endtask

    // Full frame; the i-th word sent carries byte b0+i. rev sends indices 7..0.
    task automatic send_frame(input logic [4:0] act, input bit rev,
                              input logic [7:0] b0, input logic [63:0] ts);
        exp_t        e;
        logic [63:0] v;
        logic [2:0]  idx;
        v = '0;
        for (int i = 0; i < 8; i++) begin
            idx = rev ? 3'(7 - i) : 3'(i);
            v[(7 - int'(idx)) * 8 +: 8] = b0 + 8'(i);
            localts = ts + 64'(i) * 64'h100;
            if (i == 7) begin
                e.act = act;
                e.val = v;
                e.arr = ts;
                e.cyc = cyc + 2;
                sb.push_back(e);
            end
            send_data(act, idx, b0 + 8'(i));
        end
    endtask

    initial begin
        resetn          = 1'b0;
        rxdata          = 16'h00bc;
        rxcharisk       = 2'b01;
        rxdisperr       = 2'b00;
        rxnotintable    = 2'b00;
        rxbyteisaligned = 1'b1;
        localts         = '0;
        clr_cnt         = 1'b0;
        repeat (3) @(negedge clk);

        check_eq("rst_ts_valid", 64'(ts_valid), 64'd0);
        check_eq("rst_ts_action", 64'(ts_action), 64'd0);
        check_eq("rst_ts_value", ts_value, 64'd0);
        check_eq("rst_ts_arrival", ts_arrival, 64'd0);
        check_eq("rst_alignreq", 64'(alignreq), 64'd0);
        check_eq("rst_frame_err", 64'(frame_err), 64'd0);
        check_eq("rst_frame_err_cnt", 64'(frame_err_cnt), 64'd0);
        check_eq("rst_code_err_cnt", 64'(code_err_cnt), 64'd0);
        resetn = 1'b1;
        send_idle(3);

        // Clean in-order frame
        send_frame(5'd1, 1'b0, 8'h01, 64'h1234);
        send_idle(4);
        check_eq("clean_sb_empty", 64'(sb.size()), 64'd0);

        // Out-of-order frame
        send_frame(5'd3, 1'b1, 8'h10, 64'habc0);
        send_idle(4);
        check_eq("ooo_sb_empty", 64'(sb.size()), 64'd0);

        // Interrupted frame, outputs must hold the last good frame
        for (int i = 0; i < 4; i++) send_data(5'd2, 3'(i), 8'h20 + 8'(i));
        send_idle(3);
        check_eq("intr_frame_err_pulses", 64'(fe_seen), 64'd1);
        check_eq("intr_frame_err_cnt", 64'(frame_err_cnt), 64'd1);
        check_eq("hold_ts_value", ts_value, 64'h1716151413121110);
        check_eq("hold_ts_action", 64'(ts_action), 64'd3);
        send_frame(5'd2, 1'b0, 8'h30, 64'h5555);
        send_idle(4);

        // Duplicate index
        send_data(5'd4, 3'd0, 8'h40);
        send_data(5'd4, 3'd1, 8'h41);
        send_data(5'd4, 3'd1, 8'h42);
        send_idle(3);
        check_eq("dup_frame_err_pulses", 64'(fe_seen), 64'd2);
        check_eq("dup_frame_err_cnt", 64'(frame_err_cnt), 64'd2);
        send_frame(5'd4, 1'b0, 8'h50, 64'h6000);
        send_idle(4);

        // Back-to-back frames
        send_frame(5'd1, 1'b0, 8'h60, 64'h7000);
        send_frame(5'd2, 1'b1, 8'h70, 64'h8000);
        send_idle(4);
        check_eq("b2b_sb_empty", 64'(sb.size()), 64'd0);

        // Align request and an ignored non-timestamp action
        send(16'h01bc, 2'b01, 2'b00, 2'b00);
        send_data(5'd7, 3'd0, 8'haa);
        send_idle(3);
        check_eq("alignreq_pulses", 64'(al_seen), 64'd1);
        check_eq("bad_action_no_err", 64'(fe_seen), 64'd2);

        // Code errors in IDLE: counted, no frame abort
        for (int i = 0; i < 3; i++) send(16'h0800, 2'b00, 2'b10, 2'b00);
        send_idle(2);
        check_eq("code_err_cnt_3", 64'(code_err_cnt), 64'd3);
        check_eq("code_err_no_frame_err", 64'(fe_seen), 64'd2);

        // Alignment lost mid-frame: exactly one abort
        for (int i = 0; i < 3; i++) send_data(5'd1, 3'(i), 8'h80 + 8'(i));
        rxbyteisaligned = 1'b0;
        send_idle(3);
        rxbyteisaligned = 1'b1;
        send_idle(3);
        check_eq("align_drop_pulses", 64'(fe_seen), 64'd3);
        check_eq("align_drop_cnt", 64'(frame_err_cnt), 64'd3);
        send_frame(5'd3, 1'b0, 8'h90, 64'h9000);
        send_idle(4);

        // Clear both counters
        clr_cnt = 1'b1;
        send_idle(1);
        clr_cnt = 1'b0;
        send_idle(1);
        check_eq("clr_frame_err_cnt", 64'(frame_err_cnt), 64'd0);
        check_eq("clr_code_err_cnt", 64'(code_err_cnt), 64'd0);

        // Saturation: 2^CNTW+5 code errors
        for (int i = 0; i < (1 << CNTW) + 5; i++) send(16'h0000, 2'b00, 2'b01, 2'b00);
        send_idle(2);
        check_eq("code_err_saturated", 64'(code_err_cnt), 64'(16'hffff));
        check_eq("sat_frame_err_cnt", 64'(frame_err_cnt), 64'd0);

        // Asynchronous reset mid-frame discards the partial frame
        fe_mark = fe_seen;
        for (int i = 0; i < 4; i++) send_data(5'd1, 3'(i), 8'ha0 + 8'(i));
        resetn = 1'b0;
        #1;
        check_eq("midrst_ts_value", ts_value, 64'd0);
        check_eq("midrst_code_err_cnt", 64'(code_err_cnt), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 4; i < 8; i++) send_data(5'd1, 3'(i), 8'ha0 + 8'(i));
        send_idle(4);
        check_eq("midrst_no_frame_err", 64'(fe_seen), 64'(fe_mark + 1));
        send_frame(5'd2, 1'b0, 8'hb0, 64'hb000);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        check_eq("final_sb_drain", 64'(sb.size()), 64'd0);
        send_idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/icc_sync_rx.md
Name: icc_sync_rx

Overview:
- Receive-side decoder for the inter-chassis clock-sync word protocol on the 16-bit 8b/10b GT link.
- Parses {action[4:0], index[2:0], byte[7:0]} data words into 64-bit timestamps {count48, phase16}.
- Captures the local arrival timestamp of each frame and flags align requests and link/protocol errors.
- Sits between GT rx data (already moved to the fabric clock) and the sync state machine, which consumes ts_valid strobes.

Parameters:
- DWIDTH, 16, GT data width; only 16 is supported.
- CNTW, 16, width of the saturating error counters.

Ports:
- clk  input  1  fabric clock (the GT tx user clock domain)
- resetn  input  1  asynchronous active-low reset
- rxdata  input  16  GT rx word, already synchronised to clk
- rxcharisk  input  2  per-byte K flag
- rxdisperr  input  2  per-byte disparity error
- rxnotintable  input  2  per-byte not-in-table error
- rxbyteisaligned  input  1  GT comma alignment status
- localts  input  64  local timestamp {txcnt48, rxphdmtd16}
- clr_cnt  input  1  synchronous clear of both error counters
- ts_valid  output  1  one-cycle strobe: a complete timestamp frame was decoded
- ts_action  output  5  action code of the completed frame (1..4)
- ts_value  output  64  assembled remote timestamp
- ts_arrival  output  64  localts sampled at the first word of the frame
- alignreq  output  1  high for one cycle after each align-request word
- frame_err  output  1  one-cycle strobe: frame aborted
- frame_err_cnt  output  CNTW  saturating count of frame_err
- code_err_cnt  output  CNTW  saturating count of words carrying disperr or notintable

Behaviour:
- Reset: all outputs and internal state are 0. The state machine resets to IDLE.
- Input stage: rxdata, rxcharisk, rxdisperr, rxnotintable and rxbyteisaligned are registered once. localts is registered alongside, so the arrival time is aligned to the word.
- Word classes:
  - IDLEW: charisk==2'b01 and data==16'h00bc.
  - AREQ: charisk==2'b01 and data==16'h01bc.
  - BADK: any other non-zero charisk.
  - DATA: charisk==0.
  - BADCODE: any disperr or notintable bit set; this overrides the other classes.
- Field mapping for DATA: action=d[15:11], index=d[10:8], byte=d[7:0]. Index 0 is bits 63:56 and index 7 is bits 7:0.
- FSM state IDLE:
  - DATA with action in 1..4: load the byte at index, set mask bit[index], latch action, latch arrival=localts, go to COLLECT.
  - DATA with any other action is ignored and does not count as an error.
- FSM state COLLECT, one word per cycle:
  - DATA with the same action and an index whose mask bit is clear: store the byte and set the mask bit.
  - When the mask reaches 8'hff, go to DONE.
  - DATA with the same action and a duplicate index: abort.
  - DATA with a different action: abort.
  - IDLEW, AREQ, BADK or BADCODE: abort.
- FSM state DONE:
  - Assert ts_valid for one cycle with ts_action, ts_value and ts_arrival stable from that cycle until the next ts_valid.
  - Return to IDLE.
  - A DATA word arriving in the DONE cycle is processed as if in IDLE, so back-to-back frames lose no word.
- Abort:
  - Pulse frame_err, clear the mask and go to IDLE.
  - The aborting word is not reused as a frame start.
  - ts_* outputs keep their last valid values.
- Frames may arrive in any index order but must be contiguous. Latency from the last word at the pins to ts_valid is 2 clk.
- alignreq pulses 1 cycle after an AREQ word in the input register, in any state.
- rxbyteisaligned low (registered): force IDLE. If in COLLECT, count an abort. Hold in IDLE while low.
- code_err_cnt increments on every BADCODE word. Both counters saturate at all-ones.
- clr_cnt has priority over an increment in the same cycle.
- Asynchronous reset mid-frame discards the partial frame, with no strobe.

Decomposition:
- Package icc_sync_pkg holds:
  - IDLE_WORD=16'h00bc, AREQ_WORD=16'h01bc, K_LOW=2'b01.
  - Action enum: ACT_T1=1 .. ACT_T4=4.
  - Field bit positions.
  - State enum: IDLE, COLLECT, DONE.
- Sub-module icc_sat_counter (CNTW-wide saturating counter with clear), instantiated twice.

Test Plan:
- Clean frame: IDLEW, then action 1 with indices 0..7 carrying bytes 01..08, localts=64'h1234 at the first word → ts_valid after 2 clk, ts_action=1, ts_value=64'h0102030405060708, ts_arrival=64'h1234.
- Out-of-order frame: action 3, indices 7,6..0 with bytes 0x10..0x17 → ts_value=64'h1716151413121110, ts_valid=1 exactly once.
- Interrupted frame: action 2 indices 0..3, then IDLEW → frame_err pulse and frame_err_cnt=1. A following full action-2 frame → ts_valid with the new arrival time.
- Duplicate index: action 4 indices 0,1,1 → frame_err=1, no ts_valid. The next valid frame decodes normally.
- Back-to-back: action 1 indices 0..7 immediately followed by action 2 indices 0..7 → two ts_valid strobes, 8 clk apart, actions 1 then 2.
- Errors and alignment:
  - 16'h01bc with K=2'b01 → alignreq pulse.
  - 3 words with rxdisperr=2'b10 → code_err_cnt=3.
  - rxbyteisaligned dropped mid-frame → frame_err.
  - clr_cnt → both counters 0.
  - Force 2^CNTW+5 errors → counter holds at all-ones.
